// File: rtl/enc83_pend_pkg.sv
// Shared sizes and helpers for the 8-to-3 pending-request encoder.
// onehot8 builds the pending-clear mask; rot8 aligns the rotating search start to bit 7.
package enc_pkg;

  localparam int N_IN   = 8;
  localparam int CODE_W = 3;

  function automatic logic [N_IN-1:0] onehot8(input logic [CODE_W-1:0] code);
    return 8'(1) << code;
  endfunction

  // Rotate right: result bit j takes v[(j + sh) mod 8].
  function automatic logic [N_IN-1:0] rot8(input logic [N_IN-1:0] v,
                                           input logic [CODE_W-1:0] sh);
    logic [N_IN-1:0]   r;
    logic [CODE_W-1:0] k;
    r = '0;
    for (int j = 0; j < N_IN; j++) begin
      k    = 3'(j) + sh;
      r[j] = v[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/enc83_pend_if.sv
// Code offer channel: producer drives o_code/o_valid, consumer drives o_ready.
// A code moves when o_valid and o_ready are both high on a rising edge.
interface enc83_pend_if;
  import enc_pkg::*;

  logic [CODE_W-1:0] o_code;
  logic              o_valid;
  logic              o_ready;

  modport master (output o_code, output o_valid, input o_ready);
  modport slave  (input o_code, input o_valid, output o_ready);

endinterface

// File: rtl/enc83_pend_pri.sv
// Combinational 8-to-3 priority encoder, highest set index wins; zero latency.
// Two 4-to-2 halves, the upper half taking precedence whenever it has any bit set.
module enc84_pri
  import enc_pkg::*;
(
  input  logic [N_IN-1:0]   req_vec,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  function automatic logic [2:0] pri4(input logic [3:0] v);
    logic [1:0] c;
    c = 2'd0;
    if (v[3])      c = 2'd3;
    else if (v[2]) c = 2'd2;
    else if (v[1]) c = 2'd1;
    return {|v, c};
  endfunction

  logic [2:0] hi;
  logic [2:0] lo;

  assign hi   = pri4(req_vec[7:4]);
  assign lo   = pri4(req_vec[3:0]);
  assign any  = hi[2] | lo[2];
  assign code = hi[2] ? {1'b1, hi[1:0]} : {1'b0, lo[1:0]};

endmodule

// File: rtl/enc83_pend.sv
// Pending request register feeding a one-entry code output; req to o_valid is 2 cycles, 1 code/cycle.
// Output holds while stalled and pending keeps accumulating; ENC83_RR_EN selects rotating priority.
module enc83_pend
  import enc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IN-1:0]     req_i,
  enc83_pend_if.master        out_if,
  output logic [N_IN-1:0]     pend_o,
  output logic                ovf_o
);

  logic [N_IN-1:0]   pending;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              ovf_q;
  logic [CODE_W-1:0] sel;
  logic              pri_any;
  logic              load;
  logic [N_IN-1:0]   load_oh;

`ifdef ENC83_RR_EN
  logic [CODE_W-1:0] last;
  logic [N_IN-1:0]   pend_rot;
  logic [CODE_W-1:0] rot_code;

  // Search starts just below the last granted index and wraps downward.
  assign pend_rot = rot8(pending, last);

  enc84_pri u_pri (
    .req_vec (pend_rot),
    .code    (rot_code),
    .any     (pri_any)
  );

  assign sel = rot_code + last;

  always_ff @(posedge clk) begin
    if (rst)       last <= '0;
    else if (load) last <= sel;
  end
`else
  enc84_pri u_pri (
    .req_vec (pending),
    .code    (sel),
    .any     (pri_any)
  );
`endif

  assign load    = (~valid_q | out_if.o_ready) & pri_any;
  assign load_oh = load ? onehot8(sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // OR-ing req_i last lets a fresh request survive the clear of the bit being loaded.
      pending <= (pending & ~load_oh) | req_i;
      ovf_q   <= |(req_i & pending & ~load_oh);
      if (load) begin
        code_q  <= sel;
        valid_q <= 1'b1;
      end else if (out_if.o_ready & valid_q) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.o_code  = code_q;
  assign out_if.o_valid = valid_q;
  assign pend_o         = pending;
  assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_enc83_pend.sv
// Bench for enc83_pend: expected codes are queued as requests are driven and popped on each transfer.
module tb_enc83_pend;

  logic       clk;
  logic       rst;
  logic [7:0] req_i;
  logic [7:0] pend_o;
  logic       ovf_o;

  enc83_pend_if u_if ();

  enc83_pend dut (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req_i),
    .out_if (u_if),
    .pend_o (pend_o),
    .ovf_o  (ovf_o)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_xfer = 0;
  int exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfer seen at the negedge completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst && u_if.o_valid === 1'b1 && u_if.o_ready === 1'b1) begin
      chk("sb_nonempty", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("xfer_code", int'(u_if.o_code), exp_q.pop_front());
      n_xfer++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1;
    req_i = 8'hFF;
    u_if.o_ready = 1'b0;

    // reset dominates a full request vector
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", int'(u_if.o_valid), 0);
      chk("rst_code", int'(u_if.o_code), 0);
      chk("rst_pend", int'(pend_o), 0);
      chk("rst_ovf", int'(ovf_o), 0);
    end
    rst = 1'b0;
    req_i = 8'h00;
    tick();

    // two requests, highest index first
    u_if.o_ready = 1'b1;
    req_i = 8'hA0;
    exp_q.push_back(7);
    exp_q.push_back(5);
    tick();
    req_i = 8'h00;
    chk("t2_pend", int'(pend_o), 'hA0);
    chk("t2_valid1", int'(u_if.o_valid), 0);
    tick();
    chk("t2_valid2", int'(u_if.o_valid), 1);
    chk("t2_code2", int'(u_if.o_code), 7);
    tick();
    chk("t2_code3", int'(u_if.o_code), 5);
    tick();
    chk("t2_valid4", int'(u_if.o_valid), 0);
    chk("t2_pend4", int'(pend_o), 0);

    // stall holds the offered code
    u_if.o_ready = 1'b0;
    req_i = 8'h08;
    tick();
    req_i = 8'h00;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t3_hold_valid", int'(u_if.o_valid), 1);
      chk("t3_hold_code", int'(u_if.o_code), 3);
      if (i < 5) tick();
    end
    n0 = n_xfer;
    exp_q.push_back(3);
    u_if.o_ready = 1'b1;
    tick();
    chk("t3_drop", int'(u_if.o_valid), 0);
    tick();
    chk("t3_one_xfer", n_xfer, n0 + 1);

    // overflow on a repeated request while pending
    u_if.o_ready = 1'b0;
    req_i = 8'h01;
    tick();
    req_i = 8'h00;
    tick();
    chk("t4_full", int'(u_if.o_valid), 1);
    req_i = 8'h04;
    tick();
    chk("t4_ovf_first", int'(ovf_o), 0);
    tick();
    req_i = 8'h00;
    chk("t4_ovf", int'(ovf_o), 1);
    chk("t4_pend", int'(pend_o), 'h04);
    tick();
    chk("t4_ovf_once", int'(ovf_o), 0);
    exp_q.push_back(0);
    exp_q.push_back(2);
    u_if.o_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_idle", int'(u_if.o_valid), 0);

    // saturated requests: priority sequence
`ifdef ENC83_RR_EN
    for (int i = 0; i < 8; i++) exp_q.push_back(7 - i);
    exp_q.push_back(7);
`else
    for (int i = 0; i < 9; i++) exp_q.push_back(7);
`endif
    n0 = n_xfer;
    req_i = 8'hFF;
    tick();
    tick();
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t5_pend_full", int'(pend_o), 'hFF);
    end
    u_if.o_ready = 1'b0;
    req_i = 8'h00;
    chk("t5_xfers", n_xfer, n0 + 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_pend", int'(pend_o), 0);

    // reset mid-transfer
    req_i = 8'h01;
    tick();
    req_i = 8'h00;
    tick();
    req_i = 8'hC3;
    tick();
    req_i = 8'h00;
    chk("t6_pend", int'(pend_o), 'hC3);
    chk("t6_valid", int'(u_if.o_valid), 1);
    n0 = n_xfer;
    rst = 1'b1;
    u_if.o_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid_rst", int'(u_if.o_valid), 0);
    chk("t6_pend_rst", int'(pend_o), 0);
    chk("t6_code_rst", int'(u_if.o_code), 0);
    tick();
    tick();
    chk("t6_no_xfer", n_xfer, n0);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
